// File: rtl/sim_sram_pkg.sv
// Shared types and constants for the simulation SRAM burst reader.
package sim_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } sram_rd_state_e;

    localparam int unsigned SRAM_WORD_BYTES = 4;
    localparam int unsigned SRAM_RD_LATENCY = 1;

endpackage

// File: rtl/sim_sram_rd_fifo.sv
// Two-entry return-data FIFO between the SRAM read port and the output stream.
module sim_sram_rd_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sim_sram_burst_reader.sv
// Reads a burst of consecutive words from the simulation SRAM starting at
// start_addr and returns them on a valid/ready stream.
module sim_sram_burst_reader
    import sim_sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              sram_req,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(SRAM_WORD_BYTES);

    sram_rd_state_e    r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [LEN_W-1:0]  r_issue_cnt;
    logic [LEN_W-1:0]  r_out_cnt;
    logic              r_sram_req;
    logic              r_inflight;

    logic [ADDR_W-1:0] w_start_word;
    logic [DATA_W-1:0] w_head;
    logic [1:0]        w_count;
    logic [2:0]        w_pending;
    logic              w_out_valid;
    logic              w_out_last;
    logic              w_hs;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;

    assign w_start_word = start_addr & ~(WORD_STEP - ADDR_W'(1));

    // Returning data bypasses an empty FIFO so a word is visible the cycle it
    // arrives; if it is not accepted that cycle it is pushed and held there.
    assign w_out_valid = (w_count != 2'd0) || r_inflight;
    assign w_hs        = w_out_valid && out_ready;
    assign w_pop       = w_hs && (w_count != 2'd0);
    assign w_push      = r_inflight && !(w_hs && (w_count == 2'd0));
    assign w_out_last  = w_out_valid && (r_out_cnt == LEN_W'(1));

    // Credit counts FIFO words plus both read-pipeline stages, less the word
    // leaving this cycle, so at most two words are ever owed to the FIFO.
    assign w_pending = 3'(w_count) + 3'(r_inflight) + 3'(r_sram_req);
    assign w_issue   = (r_state == READ) && (r_issue_cnt != '0)
                       && (w_pending < (3'd2 + 3'(w_hs)));

    sim_sram_rd_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (sram_rdata),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // The first read goes out on the start edge, so r_issue_cnt holds the
    // reads still to issue after it (len - 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_sram_addr <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_sram_req  <= 1'b0;
            r_inflight  <= 1'b0;
        end else begin
            r_sram_req <= 1'b0;
            r_inflight <= r_sram_req;
            if (w_hs) begin
                r_out_cnt <= r_out_cnt - LEN_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            r_state <= FIN;
                        end else begin
                            r_state     <= READ;
                            r_sram_req  <= 1'b1;
                            r_sram_addr <= w_start_word;
                            r_addr      <= w_start_word + WORD_STEP;
                            r_issue_cnt <= len - LEN_W'(1);
                            r_out_cnt   <= len;
                        end
                    end
                end
                READ: begin
                    if (r_issue_cnt == '0) begin
                        r_state <= DRAIN;
                    end else if (w_issue) begin
                        r_sram_req  <= 1'b1;
                        r_sram_addr <= r_addr;
                        r_addr      <= r_addr + WORD_STEP;
                        r_issue_cnt <= r_issue_cnt - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (w_hs && w_out_last) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIN);
    assign sram_req  = r_sram_req;
    assign sram_addr = r_sram_addr;
    assign out_valid = w_out_valid;
    assign out_last  = w_out_last;
    assign out_data  = (w_count != 2'd0) ? w_head :
                       (r_inflight ? sram_rdata : '0);

endmodule

// File: tb/tb_sim_sram_burst_reader.sv
// Directed bench for sim_sram_burst_reader with a one-cycle-latency SRAM model.
module tb_sim_sram_burst_reader;

    localparam logic [31:0] MAGIC = 32'hC3C3_5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        sram_req;
    logic [31:0] sram_addr;
    logic [31:0] sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    int total = 0;
    int bad   = 0;

    logic        clr;
    int          ncyc, start_c, first_req_c, first_beat_c, last_beat_c, done_c;
    int          req_n, beat_n, done_n, busy_n, valid_n, max_out, viol;
    logic [31:0] req_addr  [16];
    logic [31:0] beat_data [16];
    logic        beat_last [16];
    logic        pv, pr, pl;
    logic [31:0] pd;
    logic [3:0]  pat = 4'b1001;

    sim_sram_burst_reader #(
        .DATA_W (32),
        .ADDR_W (32),
        .LEN_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .sram_req   (sram_req),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sram_rdata <= sram_req ? (sram_addr ^ MAGIC) : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (clr) begin
            ncyc = 0; start_c = -1; first_req_c = -1; first_beat_c = -1;
            last_beat_c = -1; done_c = -1; req_n = 0; beat_n = 0;
            done_n = 0; busy_n = 0; valid_n = 0; max_out = 0; viol = 0;
            pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        end else begin
            ncyc++;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (start && !busy && start_c < 0) start_c = ncyc;
                if (sram_req) begin
                    if (req_n == 0) first_req_c = ncyc;
                    if (req_n < 16) req_addr[req_n] = sram_addr;
                    req_n++;
                end
                if (req_n - beat_n > max_out) max_out = req_n - beat_n;
                if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) viol++;
                if (out_valid) valid_n++;
                if (out_valid && out_ready) begin
                    if (beat_n == 0) first_beat_c = ncyc;
                    last_beat_c = ncyc;
                    if (beat_n < 16) begin
                        beat_data[beat_n] = out_data;
                        beat_last[beat_n] = out_last;
                    end
                    beat_n++;
                end
                if (done) begin
                    if (done_n == 0) done_c = ncyc;
                    done_n++;
                end
                if (busy) busy_n++;
                pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic run_burst(input logic [31:0] a, input logic [7:0] l,
                             input bit toggle, input bit poke);
        bit fin = 0;
        bit ok  = 0;
        clear_mon();
        start = 1'b1; start_addr = a; len = l; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 200; c++) begin
            out_ready = toggle ? pat[c % 4] : 1'b1;
            start = 1'b0;
            if (poke && c == 2) begin
                start = 1'b1; start_addr = 32'h0000_9990; len = 8'd5;
            end
            if (poke && done && !fin) begin
                start = 1'b1; start_addr = 32'h0000_7770; len = 8'd6;
            end
            if (done) fin = 1;
            else if (fin) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; out_ready = 1'b1;
        check("burst_end", 32'(ok), 32'd1);
    endtask

    task automatic check_burst(input logic [31:0] base, input int l, input bit timed);
        logic [31:0] ea;
        check("req_n", req_n, l);
        check("beat_n", beat_n, l);
        for (int i = 0; i < l && i < 16; i++) begin
            ea = base + 32'(4 * i);
            check($sformatf("addr%0d", i), req_addr[i], ea);
            check($sformatf("data%0d", i), beat_data[i], ea ^ MAGIC);
            check($sformatf("last%0d", i), 32'(beat_last[i]), 32'(i == l - 1));
        end
        check("done_n", done_n, 1);
        check("busy_n", busy_n, done_c - start_c);
        check("max_out", 32'(max_out <= 2), 32'd1);
        check("stable", viol, 0);
        if (l == 0) begin
            check("valid_n0", valid_n, 0);
            check("done_c0", done_c, start_c + 1);
        end else begin
            check("done_after_last", done_c, last_beat_c + 1);
        end
        if (timed && l > 0) begin
            check("first_req_c", first_req_c, start_c + 1);
            check("first_beat_c", first_beat_c, start_c + 2);
            check("last_beat_c", last_beat_c, start_c + 1 + l);
            check("busy_len", busy_n, l + 2);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_done"}, 32'(done), 0);
        check({pfx, "_req"}, 32'(sram_req), 0);
        check({pfx, "_addr"}, sram_addr, 0);
        check({pfx, "_valid"}, 32'(out_valid), 0);
        check({pfx, "_last"}, 32'(out_last), 0);
        check({pfx, "_data"}, out_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b1; clr = 1'b1;
        #12;
        check_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        check_zero("idle");

        run_burst(32'h0000_1234, 8'd4, 0, 0);
        check_burst(32'h0000_1234, 4, 1);

        run_burst(32'h0000_1234, 8'd4, 1, 0);
        check_burst(32'h0000_1234, 4, 0);

        run_burst(32'hFFFF_FFF8, 8'd3, 0, 0);
        check_burst(32'hFFFF_FFF8, 3, 1);
        check("wrap_addr2", req_addr[2], 32'h0000_0000);

        run_burst(32'h0000_5550, 8'd0, 0, 0);
        check_burst(32'h0000_5550, 0, 0);

        // Reset after the second beat of an 8-word burst.
        clear_mon();
        start = 1'b1; start_addr = 32'h0000_4000; len = 8'd8;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            if (beat_n >= 2) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rst_wait", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1 check_zero("async");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_beats", beat_n, 0);
        check("post_rst_reqs", req_n, 0);
        check("post_rst_valid", valid_n, 0);

        run_burst(32'h0000_1236, 8'd2, 0, 0);
        check_burst(32'h0000_1234, 2, 1);

        run_burst(32'h0000_2000, 8'd3, 1, 1);
        check_burst(32'h0000_2000, 3, 0);
        repeat (4) @(posedge clk);
        #1;
        check("poke_idle_busy", 32'(busy), 0);
        check("poke_idle_reqs", req_n, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
